fwd_hazard_unit: RTL
====================

# fwd_hazard_unit

Parametrised operand-forwarding and hazard unit for the EX stage of the pipelined RV32I core. It replaces the fixed two-stage MEM/WB select logic with N forwarding stages and M source operands, and returns the final operand values instead of mux selects. It adds a load-wait state machine that holds EX until a pending load's data is available. It also keeps a shadow buffer of results retired while EX is frozen, so the held instruction never reads a stale value from its ID/EX latch.

## Interface
Parameters:
- XLEN, 32, data width
- REG_AW, 5, register address width
- NUM_SRC, 2, source operands per EX instruction
- NUM_FWD, 2, forwarding stages; index 0 = nearest (MEM), NUM_FWD-1 = oldest (WB)
- SHADOW_DEPTH, 2, shadow buffer entries

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- ex_rs_addr  in  NUM_SRC x REG_AW  EX source register numbers
- ex_rs_rdata  in  NUM_SRC x XLEN  register-file values latched in ID/EX
- ex_advance  in  1  EX instruction leaves EX this cycle
- stg_rd  in  NUM_FWD x REG_AW  destination register per stage
- stg_wb  in  NUM_FWD  stage writes a register
- stg_pending  in  NUM_FWD  stage result not yet valid (load awaiting dmem)
- stg_data  in  NUM_FWD x XLEN  stage result
- wb_retire  in  1  oldest stage writes the register file this cycle
- ex_operand  out  NUM_SRC x XLEN  forwarded operand values
- load_stall  out  1  freeze IF/ID/EX; reset 0
- shadow_ovf  out  1  sticky overflow flag; reset 0

## Operation
- Match for stage i and source s: stg_wb[i] && stg_rd[i]==ex_rs_addr[s] && stg_rd[i]!=0. Register x0 never matches anything, including the shadow buffer.
- Operand priority, highest first:
  1. the lowest-index matching stage;
  2. the newest matching shadow entry;
  3. ex_rs_rdata[s].
- Hazard: the selected winning stage has stg_pending=1. A pending stage shadowed by a nearer non-pending match is not a hazard.
- FSM states and transitions:
  - RUN: load_stall = (any source has a hazard).
  - RUN to WAIT when a hazard exists.
  - WAIT: load_stall = (hazard still exists), re-evaluated every cycle.
  - WAIT to RUN in the first cycle with no hazard; load_stall is 0 in that cycle.
- Shadow capture condition: wb_retire && !ex_advance && stg_rd[NUM_FWD-1]!=0. The entry is {rd, stg_data[NUM_FWD-1]}.
  - If a valid entry already holds the same rd, overwrite its data in place.
  - Otherwise append a new entry.
  - If the buffer is full, drop the capture and set shadow_ovf. The flag stays set until reset.
- Shadow flush: ex_advance=1 invalidates all entries at the clock edge. Flush wins over a simultaneous capture.
- Reset: all shadow entries invalid, FSM to RUN, shadow_ovf=0. Reset mid-WAIT drops the stall on the next cycle.

## Timing
- ex_operand and load_stall are combinational from inputs and registered state; zero-cycle latency.
- Shadow and FSM state update on the rising edge of clk.
- A capture is visible to forwarding in the cycle after the capture edge.
- The pipeline must not assert ex_advance while load_stall=1. If it does, the flush still occurs and the FSM re-evaluates from the inputs.
- Load-use through MEM with single-cycle dmem: exactly 1 stall cycle. With a K-cycle dmem miss: K stall cycles.

## Structure
- The shared package fwd_pkg holds:
  - the typedef fwd_entry_t {logic valid; logic [REG_AW-1:0] rd; logic [XLEN-1:0] data;};
  - the FSM enum {RUN, WAIT}.
- One sub-module: fwd_shadow_buf. It contains capture, flush and overflow, and exposes per-source hit/data lookup ports.
- The top level contains the priority mux and the FSM.

## Test plan
- MEM (stage 0) rd=5, data=0xAAAA and WB rd=5, data=0xBBBB; ex_rs_addr[0]=5 -> ex_operand[0]=0xAAAA, load_stall=0.
- Stage 0 rd=3, pending=1; ex_rs_addr[1]=3 -> load_stall=1 for each pending cycle. Dropping pending with data=0x1234 -> stall=0 and ex_operand[1]=0x1234 in that cycle.
- rd=0 with stg_wb=1 in every stage; ex_rs_addr=0, ex_rs_rdata=0 -> operand 0, no stall, no shadow capture.
- ex_advance=0; WB retires rd=7, data=0x55 -> next cycle with no stage match, ex_rs_addr[0]=7 gives 0x55. After ex_advance=1, the lookup falls back to ex_rs_rdata.
- SHADOW_DEPTH=2; three retirements rd=1,2,4 during a freeze -> shadow_ovf=1 after the third, and it stays set through ex_advance. A retirement with rd=1 and new data during the same freeze updates the entry in place without overflow.
- rst_n=0 asserted during WAIT -> load_stall=0 and shadow entries invalid on the next cycle.

Source files
------------

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types for the EX-stage forwarding and hazard unit
package fwd_pkg;

  localparam int FWD_XLEN   = 32;
  localparam int FWD_REG_AW = 5;

  typedef struct packed {
    logic                  valid;
    logic [FWD_REG_AW-1:0] rd;
    logic [FWD_XLEN-1:0]   data;
  } fwd_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } fwd_state_e;

endpackage

// File: rtl/fwd_shadow_buf.sv
// rtl/fwd_shadow_buf.sv - buffer of results retired while EX is frozen
module fwd_shadow_buf
  import fwd_pkg::*;
#(
  parameter int XLEN    = FWD_XLEN,
  parameter int REG_AW  = FWD_REG_AW,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cap_retire,
  input  logic [REG_AW-1:0]               cap_rd,
  input  logic [XLEN-1:0]                 cap_data,
  input  logic                            flush,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]  lkp_addr,
  output logic [NUM_SRC-1:0]              lkp_hit,
  output logic [NUM_SRC-1:0][XLEN-1:0]    lkp_data,
  output logic                            ovf
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
  logic [DEPTH-1:0][XLEN-1:0]   data_q, data_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         ovf_q, ovf_d;
  logic [DEPTH-1:0]             same_rd;
  logic                         cap_en;

  // Valid entries always form a prefix, so cnt_q is also the append slot.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    cap_en  = cap_retire && !flush && (cap_rd != '0);
    for (int i = 0; i < DEPTH; i++) begin
      same_rd[i] = valid_q[i] && (rd_q[i] == cap_rd);
    end
    if (flush) begin
      valid_d = '0;
      cnt_d   = '0;
    end else if (cap_en) begin
      if (|same_rd) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (same_rd[i]) data_d[i] = cap_data;
        end
      end else if (cnt_q < CW'(DEPTH)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cnt_q == CW'(i)) begin
            valid_d[i] = 1'b1;
            rd_d[i]    = cap_rd;
            data_d[i]  = cap_data;
          end
        end
        cnt_d = cnt_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Later slots are newer, so the last match in slot order wins.
  always_comb begin
    lkp_hit  = '0;
    lkp_data = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && (rd_q[i] == lkp_addr[s]) && (lkp_addr[s] != '0)) begin
          lkp_hit[s]  = 1'b1;
          lkp_data[s] = data_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX operand forwarding, load-use stall FSM and shadow lookup
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int XLEN         = FWD_XLEN,
  parameter int REG_AW       = FWD_REG_AW,
  parameter int NUM_SRC      = 2,
  parameter int NUM_FWD      = 2,
  parameter int SHADOW_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]  ex_rs_addr,
  input  logic [NUM_SRC-1:0][XLEN-1:0]    ex_rs_rdata,
  input  logic                            ex_advance,
  input  logic [NUM_FWD-1:0][REG_AW-1:0]  stg_rd,
  input  logic [NUM_FWD-1:0]              stg_wb,
  input  logic [NUM_FWD-1:0]              stg_pending,
  input  logic [NUM_FWD-1:0][XLEN-1:0]    stg_data,
  input  logic                            wb_retire,
  output logic [NUM_SRC-1:0][XLEN-1:0]    ex_operand,
  output logic                            load_stall,
  output logic                            shadow_ovf
);

  logic [NUM_SRC-1:0]           sh_hit;
  logic [NUM_SRC-1:0][XLEN-1:0] sh_data;
  logic [NUM_SRC-1:0]           hazard;
  logic                         hazard_any;
  fwd_state_e                   state_q, state_d;

  fwd_shadow_buf #(
    .XLEN    (XLEN),
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC),
    .DEPTH   (SHADOW_DEPTH)
  ) u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .cap_retire (wb_retire),
    .cap_rd     (stg_rd[NUM_FWD-1]),
    .cap_data   (stg_data[NUM_FWD-1]),
    .flush      (ex_advance),
    .lkp_addr   (ex_rs_addr),
    .lkp_hit    (sh_hit),
    .lkp_data   (sh_data),
    .ovf        (shadow_ovf)
  );

  // Walk oldest to nearest so the nearest matching stage overrides.
  always_comb begin
    ex_operand = '0;
    hazard     = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      ex_operand[s] = sh_hit[s] ? sh_data[s] : ex_rs_rdata[s];
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (stg_wb[i] && (stg_rd[i] == ex_rs_addr[s]) && (stg_rd[i] != '0)) begin
          ex_operand[s] = stg_data[i];
          hazard[s]     = stg_pending[i];
        end
      end
    end
    hazard_any = |hazard;
  end

  always_comb begin
    state_d    = state_q;
    load_stall = hazard_any;
    unique case (state_q)
      RUN:     if (hazard_any)  state_d = WAIT;
      WAIT:    if (!hazard_any) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

endmodule
